// File: rtl/done_delay_unit.sv
// Multi-channel done-delay unit: re-issues each per-layer compute-done after a drain delay of (ifm_c*ofm_c)>>SHIFT cycles.
// Optional build macro DONE_DELAY_PULSE_EN: done_o becomes a one-cycle pulse and all_done_o a sticky per-layer flag.
module done_delay_unit #(
  parameter int NUM_CH = 4,
  parameter int DIM_W  = 16,
  parameter int CNT_W  = 32,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIM_W-1:0]  ifm_c,
  input  logic [DIM_W-1:0]  ofm_c,
  input  logic [NUM_CH-1:0] done_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] done_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic              all_done_o,
  output logic              any_busy_o
);

  localparam int PROD_W = 2 * DIM_W;

  // One-hot encoding: busy_o and done_o come straight from state flops.
  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_COUNT = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b100;

  logic [2:0]       state_r      [NUM_CH];
  logic [2:0]       state_nxt_s  [NUM_CH];
  logic [CNT_W-1:0] count_r      [NUM_CH];
  logic [CNT_W-1:0] count_nxt_s  [NUM_CH];
  logic [CNT_W-1:0] target_r     [NUM_CH];
  logic [CNT_W-1:0] target_nxt_s [NUM_CH];

  logic [NUM_CH-1:0] done_q_r;
  logic              primed_r;
  logic [NUM_CH-1:0] rise_s;
  logic [NUM_CH-1:0] done_s;
  logic [NUM_CH-1:0] busy_s;
  logic [PROD_W-1:0] prod_s;
  logic [CNT_W-1:0]  new_target_s;

  // Target arithmetic and rise detection
  always_comb begin
    prod_s       = PROD_W'(ifm_c) * PROD_W'(ofm_c);
    new_target_s = CNT_W'(prod_s >> SHIFT);
    // primed_r masks the first cycle after reset, so a level held high
    // through reset is absorbed into done_q_r instead of looking like a rise.
    rise_s       = done_i & ~done_q_r & {NUM_CH{primed_r}};
  end

  // State, counter, target and done history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q_r <= '0;
      primed_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]  <= S_IDLE;
        count_r[i]  <= '0;
        target_r[i] <= '0;
      end
    end else begin
      done_q_r <= done_i;
      primed_r <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i]  <= state_nxt_s[i];
        count_r[i]  <= count_nxt_s[i];
        target_r[i] <= target_nxt_s[i];
      end
    end
  end

  // Per-channel next-state logic
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt_s[i]  = state_r[i];
      count_nxt_s[i]  = count_r[i];
      target_nxt_s[i] = target_r[i];
      case (state_r[i])
        S_IDLE: begin
          if (rise_s[i]) begin
            state_nxt_s[i]  = S_COUNT;
            count_nxt_s[i]  = '0;
            target_nxt_s[i] = new_target_s;
          end else begin
            state_nxt_s[i]  = S_IDLE;
          end
        end
        S_COUNT: begin
          if (!done_i[i]) begin
            state_nxt_s[i] = S_IDLE;
            count_nxt_s[i] = '0;
          end else if (count_r[i] == target_r[i]) begin
            state_nxt_s[i] = S_DONE;
          end else begin
            count_nxt_s[i] = count_r[i] + CNT_W'(1);
          end
        end
        S_DONE: begin
`ifdef DONE_DELAY_PULSE_EN
          state_nxt_s[i] = S_IDLE;
`else
          if (ack_i[i] || !done_i[i]) begin
            state_nxt_s[i] = S_IDLE;
          end else begin
            state_nxt_s[i] = S_DONE;
          end
`endif
        end
        default: begin
          state_nxt_s[i] = S_IDLE;
          count_nxt_s[i] = '0;
        end
      endcase
    end
  end

  // Output decode from state flops
  always_comb begin
    done_s = '0;
    busy_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      done_s[i] = state_r[i][2];
      busy_s[i] = state_r[i][1];
    end
  end

  assign done_o     = done_s;
  assign busy_o     = busy_s;
  assign any_busy_o = |busy_s;

`ifdef DONE_DELAY_PULSE_EN
  logic [NUM_CH-1:0] sticky_r;
  logic              unused_ack_s;

  assign unused_ack_s = ^ack_i;

  // Per-layer completion flags, cleared once every done_i has dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= '0;
    end else if (done_i == '0) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= sticky_r | done_s;
    end
  end

  assign all_done_o = &sticky_r;
`else
  assign all_done_o = &done_s;
`endif

endmodule

// File: tb/tb_done_delay_unit.sv
// Directed bench for done_delay_unit (default level/ack build) with a latency scoreboard.
module tb_done_delay_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ifm_c;
  logic [15:0] ofm_c;
  logic [3:0]  done_i;
  logic [3:0]  ack_i;
  wire  [3:0]  done_o;
  wire  [3:0]  busy_o;
  wire         all_done_o;
  wire         any_busy_o;

  done_delay_unit #(.NUM_CH(4), .DIM_W(16), .CNT_W(32), .SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ifm_c(ifm_c), .ofm_c(ofm_c),
    .done_i(done_i), .ack_i(ack_i), .done_o(done_o), .busy_o(busy_o),
    .all_done_o(all_done_o), .any_busy_o(any_busy_o)
  );

  always #5 clk = ~clk;

  longint edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: samples 2 time units after each rising edge.
  logic [3:0] prev_done = 4'd0;
  int         rise_cnt  [4] = '{0, 0, 0, 0};
  longint     rise_edge [4] = '{0, 0, 0, 0};
  int         busy_cnt  [4] = '{0, 0, 0, 0};
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < 4; c++) begin
      if (done_o[c] && !prev_done[c]) begin
        rise_cnt[c]  = rise_cnt[c] + 1;
        rise_edge[c] = edge_n;
      end
      if (busy_o[c]) busy_cnt[c] = busy_cnt[c] + 1;
    end
    prev_done = done_o;
  end

  typedef struct {
    int     ch;
    longint exp_edge;
    int     base;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic longint tgt(input longint a, input longint b);
    return ((a * b) >> 2) & 64'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the falling edge where done_i[ch] is raised; the rise is sampled
  // at the next edge E0 and done_o must be seen after edge E0+t+1.
  task automatic push_exp(input int ch, input longint t);
    exp_t e;
    e.ch       = ch;
    e.exp_edge = edge_n + t + 2;
    e.base     = rise_cnt[ch];
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t   e;
    int     k;
    longint obs;
    e = sb.pop_front();
    k = 0;
    while (rise_cnt[e.ch] <= e.base && k < 300) begin
      @(negedge clk);
      k++;
    end
    obs = (rise_cnt[e.ch] > e.base) ? rise_edge[e.ch] : -1;
    check(tag, obs, e.exp_edge);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int base;
    rst_n  = 1'b0;
    done_i = 4'd0;
    ack_i  = 4'd0;
    ifm_c  = 16'd0;
    ofm_c  = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_done_o", done_o, 0);
    check("rst_busy_o", busy_o, 0);
    check("rst_all_done", all_done_o, 0);
    check("rst_any_busy", any_busy_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic latency, target 8
    ifm_c = 16'd8; ofm_c = 16'd4;
    busy_cnt[0] = 0;
    done_i[0] = 1'b1;
    push_exp(0, tgt(8, 4));
    pop_check("t1_latency");
    check("t1_busy_cycles", busy_cnt[0], 9);
    r0 = rise_cnt[0];
    repeat (2) @(negedge clk);
    check("t1_hold", done_o[0], 1);
    check("t1_all_done_partial", all_done_o, 0);
    ack_i[0] = 1'b1;
    @(negedge clk);
    ack_i[0] = 1'b0;
    check("t1_ack_fall", done_o[0], 0);
    repeat (5) @(negedge clk);
    check("t1_no_retrigger", rise_cnt[0] - r0 + int'(done_o[0]), 0);
    done_i[0] = 1'b0;
    @(negedge clk);

    // Zero target
    ifm_c = 16'd0; ofm_c = 16'd64;
    done_i[1] = 1'b1;
    push_exp(1, tgt(0, 64));
    pop_check("t2_latency");
    done_i[1] = 1'b0;
    @(negedge clk);
    check("t2_drop", done_o[1], 0);

    // Early drop at count 40, target 100
    ifm_c = 16'd20; ofm_c = 16'd20;
    base = rise_cnt[2];
    done_i[2] = 1'b1;
    repeat (41) @(negedge clk);
    check("t3_busy_before", busy_o[2], 1);
    done_i[2] = 1'b0;
    @(negedge clk);
    check("t3_busy_after", busy_o[2], 0);
    repeat (120) @(negedge clk);
    check("t3_never_done", rise_cnt[2] - base, 0);

    // Staggered channels, target 16, ifm_c changed mid-count
    ifm_c = 16'd8; ofm_c = 16'd8;
    for (int c = 0; c < 4; c++) begin
      done_i[c] = 1'b1;
      push_exp(c, tgt(8, 8));
      if (c < 3) repeat (3) @(negedge clk);
    end
    @(negedge clk);
    ifm_c = 16'd1024;
    pop_check("t4_latency_ch0");
    pop_check("t4_latency_ch1");
    pop_check("t4_latency_ch2");
    check("t4_all_done_early", all_done_o, 0);
    check("t4_any_busy", any_busy_o, 1);
    pop_check("t4_latency_ch3");
    check("t4_all_done", all_done_o, 1);
    ack_i = 4'hF;
    @(negedge clk);
    ack_i = 4'h0;
    check("t4_ack_all", done_o, 0);
    done_i = 4'h0;
    repeat (2) @(negedge clk);

    // Reset mid-count, then no retrigger until done_i toggles
    ifm_c = 16'd8; ofm_c = 16'd8;
    done_i[0] = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", {done_o, busy_o, all_done_o, any_busy_o}, 0);
    base = rise_cnt[0];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_no_retrigger", (rise_cnt[0] - base) + int'(busy_o[0]), 0);
    done_i[0] = 1'b0;
    @(negedge clk);
    done_i[0] = 1'b1;
    push_exp(0, tgt(8, 8));
    pop_check("t5_rearm_latency");
    done_i[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/done_delay_unit.md
Name: done_delay_unit

Overview:
- Multi-channel, parametrised successor to the single done-delay counter in the Controller.
- Each channel takes a per-layer "compute done" level from a PE group and re-issues it after a programmable drain delay: target = (ifm_c * ofm_c) >> SHIFT.
- Downstream writeback/pooling then sees done only after the accumulation pipeline has flushed.
- Adds per-channel FSMs, a latched target, abort on early drop, ack handshake and aggregate status.

Parameters:
- NUM_CH, 4, number of independent done channels.
- DIM_W, 16, width of ifm_c / ofm_c.
- CNT_W, 32, width of per-channel counter and latched target.
- SHIFT, 2, right-shift applied to ifm_c*ofm_c to form the target.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ifm_c  in  DIM_W  input channel count of current layer.
- ofm_c  in  DIM_W  output channel count of current layer.
- done_i  in  NUM_CH  per-channel compute-done level from PE groups.
- ack_i  in  NUM_CH  per-channel consumer acknowledge of done_o.
- done_o  out  NUM_CH  per-channel delayed done.
- busy_o  out  NUM_CH  high while the channel is in COUNT.
- all_done_o  out  1  AND-reduction of done_o.
- any_busy_o  out  1  OR-reduction of busy_o.

Behaviour:
- Reset (async, rst_n low):
  - All channel FSMs go to IDLE.
  - Counters, targets and the done_i history register clear to 0.
  - done_o, busy_o, all_done_o and any_busy_o are all 0.
  - Reset asserted mid-count aborts immediately; no done is emitted.
- Target arithmetic:
  - Full 2*DIM_W-bit unsigned product, then logical right shift by SHIFT, then truncated to the CNT_W LSBs.
  - Latched on IDLE->COUNT only. Later changes to ifm_c/ofm_c do not affect a running count.
- Trigger:
  - done_i is registered into done_q each cycle.
  - A rise is defined as done_i=1 and done_q=0.
  - Only a rise triggers; a steady-high level never retriggers.
- Per-channel FSM (channels fully independent):
  - IDLE: on rise -> COUNT, with count<=0 and target latched. ack_i is ignored.
  - COUNT: busy_o=1.
    - If done_i=0 -> IDLE (abort; count<=0).
    - Else if count==target -> DONE.
    - Else count<=count+1. Increment wraps modulo 2^CNT_W; this is unreachable while count<=target.
  - DONE: done_o=1 (registered).
    - If ack_i=1 or done_i=0 -> IDLE, and done_o drops the next cycle.
    - ack and drop in the same cycle -> IDLE; drop has no extra effect.
- Latency:
  - Rise sampled at edge E0 -> done_o high after edge E0+target+1.
  - target=0 gives 1 cycle. ifm_c=0 or ofm_c=0 gives target=0.
- Re-arm: after returning to IDLE with done_i still high, the channel stays IDLE until done_i falls and rises again.
- Simultaneous events:
  - A rise while in COUNT or DONE is impossible (done_i already high).
  - ack_i during COUNT is ignored.
- Aggregate outputs:
  - all_done_o and any_busy_o are combinational from the registered state bits.
  - all_done_o is 1 only when every channel is in DONE.

Optional Feature:
- Macro: DONE_DELAY_PULSE_EN.
- Defined:
  - DONE lasts exactly one cycle: done_o is a 1-cycle pulse and the FSM returns to IDLE unconditionally. ack_i is unused.
  - all_done_o is replaced by a sticky per-layer flag. Bit i sets on channel i's pulse. all_done_o=1 once all bits are set. The flag clears when all done_i are 0.
- Undefined: level/ack behaviour as above.

Test Plan:
- Basic latency:
  - Stimulus: ifm_c=8, ofm_c=4 (target=8); rise done_i[0] at E0; ack at E0+12.
  - Required: done_o[0] rises after E0+9; busy_o[0] high for 9 cycles; done_o[0] falls the cycle after ack.
- Zero target:
  - Stimulus: ifm_c=0, ofm_c=64; rise done_i[1].
  - Required: done_o[1] high 1 cycle after the sampled rise.
- Early drop:
  - Stimulus: target=100; drop done_i[2] at count 40.
  - Required: back to IDLE, done_o[2] never asserts, busy_o[2]=0 next cycle.
- Latched target and aggregation:
  - Stimulus: rise all 4 channels staggered by 3 cycles with target=16; change ifm_c to 1024 mid-count.
  - Required: each done_o fires 17 cycles after its own rise; all_done_o=1 only after channel 3 fires.
- Reset mid-count and no retrigger:
  - Stimulus: rst_n low at count 5 while done_i stays high; release reset.
  - Required: all outputs 0 and no done_o until done_i toggles 0->1.
- DONE_DELAY_PULSE_EN build:
  - Stimulus: target=3 on 2 channels.
  - Required: each done_o is exactly a 1-cycle pulse; all_done_o stays high until both done_i are low.
